axi3_rd_arbiter: RTL and testbench

- N-to-1 AXI3 read-channel arbiter between the core's internal read clients (ICache refill, DCache refill, uncached/MMIO, page-table walker) and the single AXI3 master read port at the core boundary.
- Round-robin arbitration of AR requests; registered AR output.
- Master index is encoded in arid; R beats are routed back by rid.
- Enforces a per-client outstanding-transaction limit and reports idle/busy for fence and reset sequencing.

---
 rtl/axi3_pkg.sv | 36 +++
 rtl/axi3_rd_arbiter_if.sv | 34 +++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/axi3_rd_arbiter.sv | 160 ++++++++++++++++
 tb/tb_axi3_rd_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi3_pkg.sv
// rtl/axi3_pkg.sv - shared AXI3 encodings, fixed AR attribute values and sizing helper
package axi3_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [2:0] {
        SIZE_1B   = 3'd0,
        SIZE_2B   = 3'd1,
        SIZE_4B   = 3'd2,
        SIZE_8B   = 3'd3,
        SIZE_16B  = 3'd4,
        SIZE_32B  = 3'd5,
        SIZE_64B  = 3'd6,
        SIZE_128B = 3'd7
    } size_e;

    // Normal access, non-cacheable at the bus, unprivileged secure data.
    localparam logic [1:0] AR_LOCK  = 2'b00;
    localparam logic [3:0] AR_CACHE = 4'b0000;
    localparam logic [2:0] AR_PROT  = 3'b000;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi3_rd_arbiter_if.sv
// rtl/axi3_rd_arbiter_if.sv - AXI3 read address and read data channels of the core master port
interface axi3_rd_arbiter_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot and encoded grant
module rr_arbiter import axi3_pkg::*; #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic          found;

    // First requester at or after ptr; the second pass wraps to the lowest index.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (IW'(j) >= ptr)) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    // One-hot grant only while the consumer can take a winner.
    always_comb begin
        grant = '0;
        for (int j = 0; j < N; j++) begin
            grant[j] = en && found && (sel == IW'(j));
        end
    end

    assign grant_idx = sel;

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && |req) begin
            ptr <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
        end
    end

endmodule

// File: rtl/axi3_rd_arbiter.sv
// rtl/axi3_rd_arbiter.sv - N-to-1 AXI3 read arbiter with rid routing and outstanding limits
module axi3_rd_arbiter import axi3_pkg::*; #(
    parameter int NUM_MASTERS     = 2,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_MASTERS-1:0]          s_arvalid,
    output logic [NUM_MASTERS-1:0]          s_arready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_MASTERS*8-1:0]        s_arlen,
    input  logic [NUM_MASTERS*3-1:0]        s_arsize,
    input  logic [NUM_MASTERS*2-1:0]        s_arburst,
    output logic [NUM_MASTERS-1:0]          s_rvalid,
    input  logic [NUM_MASTERS-1:0]          s_rready,
    output logic [DATA_WIDTH-1:0]           s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            s_rlast,
    axi3_rd_arbiter_if.master               m_axi,
    output logic                            busy,
    output logic                            err_bad_rid
);

    localparam int IW = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1;
    localparam int CW = clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [CW-1:0]          cnt [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] done;
    logic [IW-1:0]          gidx;
    logic                   load_en;
    logic                   rid_ok;
    logic                   rready_c;
    logic                   busy_c;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [7:0]             sel_len;
    logic [2:0]             sel_size;
    logic [1:0]             sel_burst;

    assign load_en = !m_axi.arvalid || m_axi.arready;
    assign rid_ok  = int'(m_axi.rid) < NUM_MASTERS;

    // R routing by rid; unknown ids are sunk so the slave never deadlocks on them.
    always_comb begin
        s_rvalid = '0;
        done     = '0;
        rready_c = !rid_ok;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            s_rvalid[j] = m_axi.rvalid && (m_axi.rid == ID_WIDTH'(j));
            if (m_axi.rid == ID_WIDTH'(j)) begin
                rready_c = s_rready[j];
            end
            done[j] = s_rvalid[j] && s_rready[j] && m_axi.rlast;
        end
    end

    assign m_axi.rready = rready_c;
    assign s_rdata      = m_axi.rdata;
    assign s_rresp      = m_axi.rresp;
    assign s_rlast      = m_axi.rlast;

    // A client at its limit stays eligible when one of its bursts retires this cycle.
    always_comb begin
        eligible = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            eligible[j] = s_arvalid[j] && ((cnt[j] < CNT_MAX) || done[j]);
        end
    end

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .clk       (aclk),
        .rst_n     (aresetn),
        .req       (eligible),
        .en        (load_en),
        .grant     (s_arready),
        .grant_idx (gidx)
    );

    // Mux the winning client's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (gidx == IW'(j)) begin
                sel_addr  = s_araddr[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = s_arlen[j*8 +: 8];
                sel_size  = s_arsize[j*3 +: 3];
                sel_burst = s_arburst[j*2 +: 2];
            end
        end
    end

    // AR output register; reloads only when empty or being accepted, so fields hold under stall.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi.arvalid <= 1'b0;
            m_axi.arid    <= '0;
            m_axi.araddr  <= '0;
            m_axi.arlen   <= '0;
            m_axi.arsize  <= '0;
            m_axi.arburst <= '0;
        end else if (load_en) begin
            m_axi.arvalid <= |s_arready;
            if (|s_arready) begin
                m_axi.arid    <= ID_WIDTH'(gidx);
                m_axi.araddr  <= sel_addr;
                m_axi.arlen   <= sel_len;
                m_axi.arsize  <= sel_size;
                m_axi.arburst <= sel_burst;
            end
        end
    end

    assign m_axi.arlock  = AR_LOCK;
    assign m_axi.arcache = AR_CACHE;
    assign m_axi.arprot  = AR_PROT;

    // Per-client count of granted bursts whose last beat has not yet been accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (s_arready[j] && !done[j]) begin
                    cnt[j] <= cnt[j] + CW'(1);
                end else if (!s_arready[j] && done[j]) begin
                    cnt[j] <= cnt[j] - CW'(1);
                end
            end
        end
    end

    // Busy while a request is queued or any burst is still in flight.
    always_comb begin
        busy_c = m_axi.arvalid;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            busy_c = busy_c || (cnt[j] != '0);
        end
    end

    assign busy = busy_c;

    // Sticky flag for beats carrying an id no client owns.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_bad_rid <= 1'b0;
        end else if (m_axi.rvalid && !rid_ok) begin
            err_bad_rid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb/tb_axi3_rd_arbiter.sv - directed self-checking bench for axi3_rd_arbiter
module tb_axi3_rd_arbiter;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h1C00_0000;

    logic        aclk;
    logic        aresetn;
    logic [1:0]  s_arvalid;
    logic [1:0]  s_arready;
    logic [63:0] s_araddr;
    logic [15:0] s_arlen;
    logic [5:0]  s_arsize;
    logic [3:0]  s_arburst;
    logic [1:0]  s_rvalid;
    logic [1:0]  s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        busy;
    logic        err_bad_rid;

    int n_tests = 0;
    int n_fail  = 0;

    axi3_rd_arbiter_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi3_rd_arbiter #(
        .NUM_MASTERS(2), .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_araddr    (s_araddr),
        .s_arlen     (s_arlen),
        .s_arsize    (s_arsize),
        .s_arburst   (s_arburst),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rlast     (s_rlast),
        .m_axi       (axi),
        .busy        (busy),
        .err_bad_rid (err_bad_rid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s_arvalid   = 2'b00;
        s_rready    = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rid     = 4'd0;
        axi.rdata   = 32'd0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        s_araddr  = {A1, A0};
        s_arlen   = {8'd3, 8'd7};
        s_arsize  = {3'd2, 3'd2};
        s_arburst = {2'b01, 2'b01};
        idle_inputs();
        aresetn = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_s_arready", s_arready, 0);
        check("rst_err", err_bad_rid, 0);
        check("rst_araddr", axi.araddr, 0);
        tick();
        aresetn = 1'b1;
        tick();

        // Single request from client 1, four-beat burst
        s_arvalid   = 2'b10;
        axi.arready = 1'b1;
        #1;
        check("t1_s_arready", s_arready, 2'b10);
        tick();
        s_arvalid = 2'b00;
        #1;
        check("t1_arvalid", axi.arvalid, 1);
        check("t1_araddr", axi.araddr, A1);
        check("t1_arlen", axi.arlen, 3);
        check("t1_arid", axi.arid, 1);
        check("t1_arburst", axi.arburst, 1);
        check("t1_arlock", {axi.arlock, axi.arcache, axi.arprot}, 0);
        check("t1_no_regrant", s_arready, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_arvalid_clr", axi.arvalid, 0);
        check("t1_busy_inflight", busy, 1);
        axi.rvalid = 1'b1;
        axi.rid    = 4'd1;
        s_rready   = 2'b10;
        for (int b = 0; b < 4; b++) begin
            axi.rlast = (b == 3);
            axi.rdata = 32'hD000_0000 + b;
            #1;
            check("t1_s_rvalid", s_rvalid, 2'b10);
            check("t1_rready", axi.rready, 1);
            check("t1_s_rdata", s_rdata, 32'hD000_0000 + b);
            check("t1_busy_beat", busy, 1);
            tick();
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        #1;
        check("t1_busy_done", busy, 0);

        // Fairness: both clients requesting continuously
        do_reset();
        s_arvalid   = 2'b11;
        axi.arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_grant", s_arready, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("t2_arid", axi.arid, k % 2);
            check("t2_araddr", axi.araddr, (k % 2 == 0) ? A0 : A1);
        end
        s_arvalid = 2'b00;

        // Backpressure: AR held stable, no further grants, then switch client
        do_reset();
        s_arvalid   = 2'b11;
        axi.arready = 1'b0;
        #1;
        check("t3_first_grant", s_arready, 2'b01);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_no_grant", s_arready, 0);
            check("t3_arvalid_hold", axi.arvalid, 1);
            check("t3_araddr_hold", axi.araddr, A0);
            check("t3_arlen_hold", axi.arlen, 7);
            tick();
        end
        axi.arready = 1'b1;
        #1;
        check("t3_next_grant", s_arready, 2'b10);
        tick();
        check("t3_next_arid", axi.arid, 1);
        check("t3_next_araddr", axi.araddr, A1);
        s_arvalid = 2'b00;

        // Outstanding limit on client 0
        do_reset();
        s_arvalid   = 2'b01;
        axi.arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_grant", s_arready, 2'b01);
            tick();
        end
        #1;
        check("t4_limit", s_arready, 0);
        tick();
        check("t4_limit_hold", s_arready, 0);
        axi.rvalid = 1'b1;
        axi.rid    = 4'd0;
        axi.rlast  = 1'b1;
        s_rready   = 2'b01;
        #1;
        check("t4_retire_grant", s_arready, 2'b01);
        check("t4_retire_rready", axi.rready, 1);
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        #1;
        check("t4_cnt_stays_max", s_arready, 0);
        check("t4_busy", busy, 1);
        s_arvalid = 2'b00;

        // R routing, stall on client 1, bad rid
        do_reset();
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b0;
        s_rready   = 2'b01;
        axi.rid    = 4'd0;
        #1;
        check("t5_rready_rid0", axi.rready, 1);
        check("t5_s_rvalid_rid0", s_rvalid, 2'b01);
        axi.rid = 4'd1;
        #1;
        check("t5_rready_rid1_stall", axi.rready, 0);
        check("t5_s_rvalid_rid1", s_rvalid, 2'b10);
        tick();
        check("t5_rready_still_stall", axi.rready, 0);
        axi.rid = 4'd0;
        #1;
        check("t5_rready_rid0_again", axi.rready, 1);
        axi.rid  = 4'd1;
        s_rready = 2'b11;
        #1;
        check("t5_rready_rid1_go", axi.rready, 1);
        check("t5_s_rvalid_rid1_go", s_rvalid, 2'b10);
        tick();
        axi.rid = 4'd5;
        #1;
        check("t5_bad_rready", axi.rready, 1);
        check("t5_bad_s_rvalid", s_rvalid, 0);
        check("t5_err_before_edge", err_bad_rid, 0);
        tick();
        check("t5_err_set", err_bad_rid, 1);
        axi.rvalid = 1'b0;
        tick();
        check("t5_err_sticky", err_bad_rid, 1);
        check("t5_busy", busy, 0);

        // Asynchronous reset in the middle of a burst
        s_arvalid   = 2'b01;
        axi.arready = 1'b0;
        tick();
        s_arvalid  = 2'b00;
        axi.rvalid = 1'b1;
        axi.rid    = 4'd0;
        s_rready   = 2'b01;
        #1;
        check("t6_busy_before", busy, 1);
        check("t6_arvalid_before", axi.arvalid, 1);
        aresetn = 1'b0;
        #1;
        check("t6_arvalid_async", axi.arvalid, 0);
        check("t6_busy_async", busy, 0);
        check("t6_err_async", err_bad_rid, 0);
        axi.rvalid = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        check("t6_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
